// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo_sync write port among NUM_REQ producers in bursts of up to MAX_BURST beats.
// Define FIFO_ARB_STATS_EN to add saturating per-requester beat counters and a full-stall counter.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt,
    output logic [CNT_WIDTH-1:0]          stall_cnt
`endif
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_a;
    logic [GW-1:0] winner;
    logic          xfer;
    int            idx;
    logic          found;

    assign req_data_a = req_data;

    // Rotating priority: search starts just after the previous winner.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                winner = GW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        xfer         = (state_q == GRANT) && req_valid[grant_id_q] && !fifo_full;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d      = GRANT;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    beat_cnt_d   = '0;
                end
            end
            GRANT: begin
                // A stall on full holds everything; only a dropped valid or burst end releases.
                if (!req_valid[grant_id_q]) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    if (beat_cnt_q == LAST_BEAT) state_d = IDLE;
                    else                         beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = (state_q == GRANT) && (grant_id_q == GW'(i)) && !fifo_full;
    end

    assign fifo_wr_en   = xfer;
    assign fifo_data_in = xfer ? req_data_a[grant_id_q] : '0;
    assign grant_id     = grant_id_q;
    assign busy         = (state_q == GRANT);

`ifdef FIFO_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_q, grant_cnt_d;
    logic [CNT_WIDTH-1:0]              stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NUM_REQ; i++)
            if (xfer && grant_id_q == GW'(i) && grant_cnt_q[i] != '1)
                grant_cnt_d[i] = grant_cnt_q[i] + 1'b1;
        if (state_q == GRANT && req_valid[grant_id_q] && fifo_full && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default 4 requesters, 8-bit data, 4-beat bursts).
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic [63:0] grant_cnt;
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int fails  = 0;

    fifo_wr_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
        , .grant_cnt(grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; req_data = 32'h33221100; fifo_full = 1'b0;
        #23;
        checks++;
        if ({req_ready, fifo_wr_en, busy, grant_id, fifo_data_in} !== 16'h0) begin
            $display("FAIL reset_outputs: got rdy=%b wr=%b busy=%b gid=%0d data=%h, need all 0",
                     req_ready, fifo_wr_en, busy, grant_id, fifo_data_in);
            fails++;
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (grant_cnt !== '0 || stall_cnt !== '0) begin
            $display("FAIL reset_counters: got grant=%h stall=%h, need 0", grant_cnt, stall_cnt);
            fails++;
        end
`endif
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
            $display("FAIL reset_idle_cycle: got busy=%b wr=%b, need 0 0", busy, fifo_wr_en);
            fails++;
        end
        tick();
        #1;
        checks++;
        if ({busy, grant_id, fifo_wr_en, fifo_data_in, req_ready} !== {1'b1, 2'd0, 1'b1, 8'h00, 4'b0001}) begin
            $display("FAIL reset_first_grant: got busy=%b gid=%0d wr=%b data=%h rdy=%b, need 1 0 1 00 0001",
                     busy, grant_id, fifo_wr_en, fifo_data_in, req_ready);
            fails++;
        end
    endtask

    task automatic test_single_req();
        int k = 0;
        logic exp_wr;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            req_valid = 4'b0100;
            req_data[16 +: 8] = 8'hA0 + 8'(k);
            #1;
            exp_wr = (c % 5) != 0;
            checks++;
            if (fifo_wr_en !== exp_wr || busy !== exp_wr) begin
                $display("FAIL single_wr_en c%0d: got wr=%b busy=%b, need %b", c, fifo_wr_en, busy, exp_wr);
                fails++;
            end
            if (exp_wr) begin
                checks++;
                if (fifo_data_in !== 8'hA0 + 8'(k) || req_ready !== 4'b0100 || grant_id !== 2'd2) begin
                    $display("FAIL single_data c%0d: got data=%h rdy=%b gid=%0d, need %h 0100 2",
                             c, fifo_data_in, req_ready, grant_id, 8'hA0 + 8'(k));
                    fails++;
                end
                k++;
            end else if (c == 5) begin
                checks++;
                if (grant_id !== 2'd2 || req_ready !== 4'b0000) begin
                    $display("FAIL single_idle_hold: got gid=%0d rdy=%b, need 2 0000", grant_id, req_ready);
                    fails++;
                end
            end
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int beats = 0;
        logic       exp_wr;
        logic [1:0] exp_g;
        do_reset();
        req_valid = 4'hF;
        req_data  = 32'hC3C2C1C0;
        for (int c = 0; c < 25; c++) begin
            if (c > 0) tick();
            #1;
            exp_wr = (c % 5) != 0;
            exp_g  = 2'((c / 5) % 4);
            if (fifo_wr_en) beats++;
            checks++;
            if (fifo_wr_en !== exp_wr) begin
                $display("FAIL rr_wr_en c%0d: got %b, need %b", c, fifo_wr_en, exp_wr);
                fails++;
            end else if (exp_wr && (grant_id !== exp_g || fifo_data_in !== 8'hC0 + 8'(exp_g))) begin
                $display("FAIL rr_grant c%0d: got gid=%0d data=%h, need %0d %h",
                         c, grant_id, fifo_data_in, exp_g, 8'hC0 + 8'(exp_g));
                fails++;
            end
        end
        checks++;
        if (beats !== 20) begin
            $display("FAIL rr_beat_total: got %0d, need 20", beats);
            fails++;
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_full_stall();
        // c0 idle, c1-c2 beats, c3-c5 full, c6-c7 beats, c8 idle
        int k = 0;
        logic exp_wr;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c > 0) tick();
            req_valid = 4'b0010;
            req_data[8 +: 8] = 8'hB0 + 8'(k);
            fifo_full = (c >= 3 && c <= 5);
            #1;
            exp_wr = (c != 0) && !fifo_full && (c != 8);
            checks++;
            if (fifo_wr_en !== exp_wr) begin
                $display("FAIL stall_wr_en c%0d: got %b, need %b", c, fifo_wr_en, exp_wr);
                fails++;
            end
            if (fifo_full) begin
                checks++;
                if (req_ready !== 4'b0000 || grant_id !== 2'd1 || busy !== 1'b1) begin
                    $display("FAIL stall_hold c%0d: got rdy=%b gid=%0d busy=%b, need 0000 1 1",
                             c, req_ready, grant_id, busy);
                    fails++;
                end
            end
            if (exp_wr) begin
                checks++;
                if (fifo_data_in !== 8'hB0 + 8'(k)) begin
                    $display("FAIL stall_data c%0d: got %h, need %h", c, fifo_data_in, 8'hB0 + 8'(k));
                    fails++;
                end
                k++;
            end
        end
        checks++;
        if (k !== 4 || busy !== 1'b0) begin
            $display("FAIL stall_burst_end: got beats=%0d busy=%b, need 4 0", k, busy);
            fails++;
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            $display("FAIL stall_cnt: got %0d, need 3", stall_cnt);
            fails++;
        end
`endif
        tick();
        req_valid = '0;
    endtask

    task automatic test_early_release();
        do_reset();
        req_valid = 4'b0110;
        req_data  = 32'h00E2E100;
        tick(); tick(); tick();
        req_valid = 4'b0100;
        #1;
        checks++;
        if ({busy, fifo_wr_en, req_ready, grant_id} !== {1'b1, 1'b0, 4'b0010, 2'd1}) begin
            $display("FAIL early_drop: got busy=%b wr=%b rdy=%b gid=%0d, need 1 0 0010 1",
                     busy, fifo_wr_en, req_ready, grant_id);
            fails++;
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || grant_id !== 2'd1) begin
            $display("FAIL early_idle: got busy=%b wr=%b gid=%0d, need 0 0 1", busy, fifo_wr_en, grant_id);
            fails++;
        end
        tick();
        #1;
        checks++;
        if ({busy, grant_id, fifo_wr_en, fifo_data_in} !== {1'b1, 2'd2, 1'b1, 8'hE2}) begin
            $display("FAIL early_next_grant: got busy=%b gid=%0d wr=%b data=%h, need 1 2 1 e2",
                     busy, grant_id, fifo_wr_en, fifo_data_in);
            fails++;
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (grant_cnt[16 +: 16] !== 16'd2) begin
            $display("FAIL early_grant_cnt1: got %0d, need 2", grant_cnt[16 +: 16]);
            fails++;
        end
`endif
        tick();
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_valid = 4'b1000;
        req_data  = 32'h5A000000;
        tick(); tick();
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || req_ready !== 4'b1000) begin
            $display("FAIL midrst_pre: got wr=%b rdy=%b, need 1 1000", fifo_wr_en, req_ready);
            fails++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_wr_en, req_ready, busy, fifo_data_in} !== 14'h0) begin
            $display("FAIL midrst_async: got wr=%b rdy=%b busy=%b data=%h, need 0",
                     fifo_wr_en, req_ready, busy, fifo_data_in);
            fails++;
        end
`ifdef FIFO_ARB_STATS_EN
        checks++;
        if (grant_cnt !== '0 || stall_cnt !== '0) begin
            $display("FAIL midrst_counters: got grant=%h stall=%h, need 0", grant_cnt, stall_cnt);
            fails++;
        end
`endif
        req_valid = 4'hF;
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (busy !== 1'b1 || grant_id !== 2'd0) begin
            $display("FAIL midrst_regrant: got busy=%b gid=%0d, need 1 0", busy, grant_id);
            fails++;
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_req();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_mid_reset();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
